// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub: the master drives operands and
// consumer ready, the slave (the unit) returns results, overflow status and occupancy.
interface pipe_addsub_if #(
  parameter int W  = 10,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          ovf;
  logic          ovf_clr;
  logic [CW-1:0] ovf_cnt;
  logic          busy;

  modport master (
    output in_valid, op, a, b, out_ready, ovf_clr,
    input  in_ready, out_valid, y, ovf, ovf_cnt, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready, ovf_clr,
    output in_ready, out_valid, y, ovf, ovf_cnt, busy
  );
endinterface

// File: rtl/pipe_addsub.sv
// Wrap/saturating add-sub, DEPTH-stage pipeline, results in order DEPTH cycles after acceptance.
// A single global enable freezes every stage while the last one holds an unaccepted result.
module pipe_addsub #(
  parameter int W     = 10,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  pipe_addsub_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic         w_en;
  logic         w_xfer;
  logic [W:0]   w_sum;
  logic [W:0]   w_dif;
  logic [W-1:0] w_res;
  logic         w_ovf;

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_ovf;
  logic [W-1:0]     r_res [DEPTH];
  logic [CW-1:0]    r_cnt;

  // Zero-extended operands make the top bit the carry for add and the borrow for sub.
  always_comb begin
    w_sum = {1'b0, bus.a} + {1'b0, bus.b};
    w_dif = {1'b0, bus.a} - {1'b0, bus.b};
    w_ovf = bus.op[0] ? w_dif[W] : w_sum[W];
    w_res = bus.op[0] ? w_dif[W-1:0] : w_sum[W-1:0];
    if (bus.op[1] && w_ovf) begin
      w_res = bus.op[0] ? '0 : '1;
    end
  end

  assign w_en   = !r_vld[DEPTH-1] || bus.out_ready;
  assign w_xfer = r_vld[DEPTH-1] && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_ovf <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i] <= '0;
      end
    end else if (w_en) begin
      r_vld[0] <= bus.in_valid;
      r_ovf[0] <= w_ovf;
      r_res[0] <= w_res;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_ovf[i] <= r_ovf[i-1];
        r_res[i] <= r_res[i-1];
      end
    end
  end

  // Clear wins over a coincident overflow delivery; that event is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.ovf_clr) begin
      r_cnt <= '0;
    end else if (w_xfer && r_ovf[DEPTH-1] && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_vld[DEPTH-1];
  assign bus.y         = r_res[DEPTH-1];
  assign bus.ovf       = r_ovf[DEPTH-1];
  assign bus.ovf_cnt   = r_cnt;
  assign bus.busy      = |r_vld;

endmodule
